lcd_char_responder: RTL and testbench
=====================================

Name: lcd_char_responder

Overview:
- Cycle-accurate behavioural responder for the 8-bit parallel character-LCD bus (HD44780-style) driven by our display initiators.
- Synthesizable, so it runs both in simulation and on the board. It loops the LCD bus back for self-checking display firmware.
- Samples E/RS/RW/DB, decodes commands and data, and maintains DD RAM, address counter, display shift and mode flags.
- Models busy timing and answers status and data reads on the bus.

Parameters:
- SYNC_STAGES, 2: synchronizer depth for the E/RS/RW/DB inputs.
- POWERUP_CYCLES, 700000: busy period after reset, in clocks.
- CMD_BUSY_CYCLES, 1850: busy period after any non-clear/home command or data access (37 us at 50 MHz).
- CLEAR_BUSY_CYCLES, 76000: busy period after clear or return home (1.52 ms).
- LINE_LENGTH, 40: characters per line. DD RAM holds 2*LINE_LENGTH characters.

Ports:
- CLOCK_50MHZ  in  1  system clock.
- BUTTON_SOUTH_N  in  1  reset; synchronous, active-low.
- LCD_DATA_BIT  in  8  bus data from initiator.
- LCD_ENABLE  in  1  bus strobe; command/data captured on its falling edge.
- LCD_REGISTER_SELECT  in  1  0 = instruction, 1 = data.
- LCD_READ_WRITE  in  1  0 = write, 1 = read.
- LCD_DATA_OUT  out  8  read data.
- LCD_DATA_OE  out  1  high while a read is being driven.
- BUSY  out  1  busy flag.
- CURSOR_ADDR  out  7  address counter (AC).
- SHIFT_OFFSET  out  6  display shift, 0..LINE_LENGTH-1.
- DISPLAY_ON, CURSOR_ON, BLINK_ON  out  1 each  display-control state.
- ENTRY_INC, ENTRY_SHIFT  out  1 each  entry-mode state.
- FUNC_8BIT, FUNC_2LINE  out  1 each  function-set state.
- CMD_ERROR  out  1  sticky protocol-error flag.
- RAM_RD_ADDR  in  7  debug read address, in AC address space.
- RAM_RD_CHAR  out  8  DD RAM content at RAM_RD_ADDR; registered, 1-cycle latency.

Behaviour:
- Reset (BUTTON_SOUTH_N=0 at clock edge):
  - DATA_OUT=0, OE=0, AC=0, SHIFT=0.
  - DISPLAY/CURSOR/BLINK=0, ENTRY_INC=1, ENTRY_SHIFT=0, FUNC_8BIT=1, FUNC_2LINE=0.
  - CMD_ERROR=0, BUSY=1.
  - FSM=POWERUP.
  - DD RAM is not cleared.
  - Reset mid-operation aborts any clear fill.
- Inputs pass through SYNC_STAGES flops. A falling edge is synchronized E going 1->0.
- RS/RW/DB are taken from the stage aligned with the last E=1 sample.
- FSM states: POWERUP, IDLE, EXEC, CLEARFILL.
  - POWERUP: counts POWERUP_CYCLES, then goes to IDLE with BUSY=0.
  - IDLE: on a falling-edge write, decode in the next cycle, load the busy counter, and go to EXEC (or CLEARFILL for clear). BUSY=1.
  - EXEC: counts down, then returns to IDLE with BUSY=0.
  - CLEARFILL: writes 0x20 to all 2*LINE_LENGTH locations, one per clock, then goes to EXEC. The remaining count is CLEAR_BUSY_CYCLES minus the fill length.
- Instruction decode uses the highest set bit:
  - 0x80: AC=DB[6:0]. An invalid address (0x28-0x3F, 0x68-0x7F) sets AC=0 and CMD_ERROR=1.
  - 0x40: CG RAM address; no-op, busy.
  - 0x20: FUNC_8BIT=DB[4], FUNC_2LINE=DB[3].
  - 0x10: DB[3]=1 shifts the display: R/L=0 gives SHIFT+1, R/L=1 gives SHIFT-1, mod LINE_LENGTH. DB[3]=0 moves AC: R/L=1 increments, R/L=0 decrements.
  - 0x08: DISPLAY/CURSOR/BLINK = DB[2:0].
  - 0x04: ENTRY_INC=DB[1], ENTRY_SHIFT=DB[0].
  - 0x02: AC=0, SHIFT=0; busy CLEAR_BUSY_CYCLES.
  - 0x01: clear fill, AC=0, SHIFT=0, ENTRY_INC=1.
  - 0x00: ignored, no busy.
- Data write: RAM[AC]=DB. AC then steps per ENTRY_INC. If ENTRY_SHIFT=1, SHIFT steps +1 when inc and -1 when dec.
- AC stepping: increment 0x27->0x40 and 0x67->0x00; decrement is the inverse.
- Physical RAM index: AC for line 0; AC-0x40+LINE_LENGTH for line 1.
- Reads:
  - While synchronized E=1 and RW=1, OE=1.
  - RS=0: DATA_OUT={BUSY, AC}.
  - RS=1: DATA_OUT=RAM[AC]; AC steps on the falling edge; starts CMD_BUSY.
  - Status reads are always allowed and never start busy.
- Any write during POWERUP is accepted if it is a function set (0x3x); otherwise it is dropped and CMD_ERROR=1.

Optional Feature:
- LCD_BUSY_CHECK_EN defined: a write or data read falling edge while BUSY=1 (outside POWERUP) is dropped and sets CMD_ERROR. The timing is unchanged.
- Undefined: such accesses are executed immediately and restart the busy counter. No error is raised.

Test Plan:
1. Reset, wait POWERUP. Write 0x38, 0x38, 0x38, 0x38, 0x07, 0x0C, 0x01 with ≥2000-cycle gaps, and 82000 after clear -> FUNC_8BIT=1, FUNC_2LINE=1, ENTRY_INC=1, ENTRY_SHIFT=1, DISPLAY_ON=1, CURSOR_ON=0, all RAM 0x20, CMD_ERROR=0.
2. Continue: 0x80, then data "Demmy's desk!!" -> RAM 0x00..0x0D hold 0x44..0x21, AC=0x0E, SHIFT=14.
3. Write 0x18 -> SHIFT=15. Write 0x18 twenty-five more times -> SHIFT wraps to 0.
4. 0x04 (dec), 0xA7 (AC=0x27), entry 0x06, data 'A' -> RAM[0x27]='A', AC=0x40. Data at 0x67 -> AC=0x00.
5. Clear, then status read 10 cycles later -> DATA_OUT=0x80 (BUSY=1, AC=0), OE=1. Read again after CLEAR_BUSY_CYCLES -> 0x00.
6. With LCD_BUSY_CHECK_EN: data write 100 cycles after a command -> RAM unchanged, CMD_ERROR=1. Reset asserted mid-clear-fill -> BUSY=1, FSM=POWERUP, CMD_ERROR=0.

Source files
------------

// File: rtl/lcd_char_responder.sv
// lcd_char_responder: behavioural HD44780-style character-LCD responder.
// It samples the 8-bit parallel bus (E/RS/RW/DB) and decodes instructions and
// data writes on the falling edge of E. It keeps DD RAM, the address counter,
// the display shift and the mode flags, models busy timing, and answers status
// and data reads on the bus.
// Optional build macro: LCD_BUSY_CHECK_EN. When it is defined, a write or data
// read that arrives while busy (outside power-up) is dropped and flagged.
// When it is undefined, such an access executes at once and restarts the busy
// counter.
module lcd_char_responder #(
  parameter int SYNC_STAGES       = 2,
  parameter int POWERUP_CYCLES    = 700000,
  parameter int CMD_BUSY_CYCLES   = 1850,
  parameter int CLEAR_BUSY_CYCLES = 76000,
  parameter int LINE_LENGTH       = 40
) (
  input  logic       CLOCK_50MHZ,
  input  logic       BUTTON_SOUTH_N,
  input  logic [7:0] LCD_DATA_BIT,
  input  logic       LCD_ENABLE,
  input  logic       LCD_REGISTER_SELECT,
  input  logic       LCD_READ_WRITE,
  output logic [7:0] LCD_DATA_OUT,
  output logic       LCD_DATA_OE,
  output logic       BUSY,
  output logic [6:0] CURSOR_ADDR,
  output logic [5:0] SHIFT_OFFSET,
  output logic       DISPLAY_ON,
  output logic       CURSOR_ON,
  output logic       BLINK_ON,
  output logic       ENTRY_INC,
  output logic       ENTRY_SHIFT,
  output logic       FUNC_8BIT,
  output logic       FUNC_2LINE,
  output logic       CMD_ERROR,
  input  logic [6:0] RAM_RD_ADDR,
  output logic [7:0] RAM_RD_CHAR
);

  localparam int         RAM_DEPTH   = 2 * LINE_LENGTH;
  localparam int         CLEAR_REST  = (CLEAR_BUSY_CYCLES > RAM_DEPTH) ? CLEAR_BUSY_CYCLES - RAM_DEPTH : 1;
  localparam logic [6:0] LINE_LEN7   = 7'(LINE_LENGTH);
  localparam logic [6:0] LINE0_LAST  = 7'(LINE_LENGTH - 1);
  localparam logic [6:0] LINE1_FIRST = 7'h40;
  localparam logic [6:0] LINE1_LAST  = 7'(64 + LINE_LENGTH - 1);
  localparam logic [5:0] COL_LAST    = 6'(LINE_LENGTH - 1);
  localparam logic [6:0] FILL_LAST   = 7'(RAM_DEPTH - 1);

  typedef enum logic [1:0] {POWERUP, IDLE, EXEC, CLEARFILL} state_t;

  state_t            state;
  logic [31:0]       cnt;
  logic [6:0]        fill_idx;

  logic [SYNC_STAGES-1:0] e_sync;
  logic [SYNC_STAGES-1:0] rs_sync;
  logic [SYNC_STAGES-1:0] rw_sync;
  logic [7:0]             db_sync [SYNC_STAGES];
  logic                   e_p1;
  logic                   rs_p1;
  logic                   rw_p1;
  logic [7:0]             db_p1;

  logic       cmd_vld;
  logic       cmd_rs;
  logic       cmd_rw;
  logic [7:0] cmd_db;

  logic       e_s;
  logic       rs_s;
  logic       rw_s;
  logic       fall;
  logic       cmd_write;
  logic       cmd_access;
  logic       in_powerup;
  logic       busy_reject;
  logic       do_exec;

  logic [7:0] ram [RAM_DEPTH];
  logic       ram_we;
  logic [6:0] ram_wa;
  logic [7:0] ram_wd;

  // An address is valid when its column falls inside one line.
  function automatic logic addr_valid(input logic [6:0] a);
    return a[5:0] <= COL_LAST;
  endfunction

  // Map the AC address space onto the packed DD RAM index.
  function automatic logic [6:0] phys(input logic [6:0] a);
    return a[6] ? ({1'b0, a[5:0]} + LINE_LEN7) : {1'b0, a[5:0]};
  endfunction

  // AC stepping that hops the gap between line 0 and line 1.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == LINE0_LAST) return LINE1_FIRST;
      if (a == LINE1_LAST) return 7'h00;
      return a + 7'd1;
    end
    if (a == 7'h00) return LINE1_LAST;
    if (a == LINE1_FIRST) return LINE0_LAST;
    return a - 7'd1;
  endfunction

  // The display shift wraps modulo the line length.
  function automatic logic [5:0] shift_step(input logic [5:0] s, input logic up);
    if (up) return (s == COL_LAST) ? 6'd0 : s + 6'd1;
    return (s == 6'd0) ? COL_LAST : s - 6'd1;
  endfunction

  assign e_s  = e_sync[SYNC_STAGES-1];
  assign rs_s = rs_sync[SYNC_STAGES-1];
  assign rw_s = rw_sync[SYNC_STAGES-1];
  assign fall = e_p1 && !e_s;

  assign cmd_write  = cmd_vld && !cmd_rw;
  assign cmd_access = cmd_write || (cmd_vld && cmd_rw && cmd_rs);
  assign in_powerup = (state == POWERUP);
`ifdef LCD_BUSY_CHECK_EN
  assign busy_reject = cmd_access && BUSY && !in_powerup;
`else
  assign busy_reject = 1'b0;
`endif
  assign do_exec = cmd_access && !in_powerup && !busy_reject;

  // Strobe synchronizer plus one stage to detect the falling edge.
  always_ff @(posedge CLOCK_50MHZ) begin
    if (!BUTTON_SOUTH_N) begin
      e_sync <= '0;
      e_p1   <= 1'b0;
    end else begin
      e_sync[0] <= LCD_ENABLE;
      for (int i = 1; i < SYNC_STAGES; i++) e_sync[i] <= e_sync[i-1];
      e_p1 <= e_s;
    end
  end

  // RS/RW/DB synchronizer, kept aligned with the strobe stages.
  always_ff @(posedge CLOCK_50MHZ) begin
    rs_sync[0] <= LCD_REGISTER_SELECT;
    rw_sync[0] <= LCD_READ_WRITE;
    db_sync[0] <= LCD_DATA_BIT;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      rs_sync[i] <= rs_sync[i-1];
      rw_sync[i] <= rw_sync[i-1];
      db_sync[i] <= db_sync[i-1];
    end
    rs_p1 <= rs_s;
    rw_p1 <= rw_s;
    db_p1 <= db_sync[SYNC_STAGES-1];
  end

  // Capture the bus cycle that just ended; it is decoded on the next clock.
  always_ff @(posedge CLOCK_50MHZ) begin
    if (!BUTTON_SOUTH_N) cmd_vld <= 1'b0;
    else                 cmd_vld <= fall;
    if (fall) begin
      cmd_rs <= rs_p1;
      cmd_rw <= rw_p1;
      cmd_db <= db_p1;
    end
  end

  // Main controller: busy timing, clear fill, and instruction/data execution.
  always_ff @(posedge CLOCK_50MHZ) begin
    if (!BUTTON_SOUTH_N) begin
      state        <= POWERUP;
      cnt          <= 32'(POWERUP_CYCLES);
      fill_idx     <= 7'd0;
      ram_we       <= 1'b0;
      BUSY         <= 1'b1;
      CURSOR_ADDR  <= 7'd0;
      SHIFT_OFFSET <= 6'd0;
      DISPLAY_ON   <= 1'b0;
      CURSOR_ON    <= 1'b0;
      BLINK_ON     <= 1'b0;
      ENTRY_INC    <= 1'b1;
      ENTRY_SHIFT  <= 1'b0;
      FUNC_8BIT    <= 1'b1;
      FUNC_2LINE   <= 1'b0;
      CMD_ERROR    <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      unique case (state)
        POWERUP, EXEC: begin
          if (cnt <= 32'd1) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        CLEARFILL: begin
          ram_we <= 1'b1;
          ram_wa <= fill_idx;
          ram_wd <= 8'h20;
          if (fill_idx == FILL_LAST) begin
            state <= EXEC;
            cnt   <= 32'(CLEAR_REST);
          end else begin
            fill_idx <= fill_idx + 7'd1;
          end
        end
        default: ;
      endcase

      // During power-up only a function set gets through.
      if (in_powerup && cmd_write) begin
        if (!cmd_rs && cmd_db[7:4] == 4'h3) begin
          FUNC_8BIT  <= cmd_db[4];
          FUNC_2LINE <= cmd_db[3];
        end else begin
          CMD_ERROR <= 1'b1;
        end
      end

      if (busy_reject) CMD_ERROR <= 1'b1;

      // Assignments below override the timing updates above when an access executes.
      if (do_exec) begin
        if (cmd_rs) begin
          if (!cmd_rw) begin
            ram_we <= 1'b1;
            ram_wa <= phys(CURSOR_ADDR);
            ram_wd <= cmd_db;
            if (ENTRY_SHIFT) SHIFT_OFFSET <= shift_step(SHIFT_OFFSET, ENTRY_INC);
          end
          CURSOR_ADDR <= ac_step(CURSOR_ADDR, ENTRY_INC);
          state       <= EXEC;
          BUSY        <= 1'b1;
          cnt         <= 32'(CMD_BUSY_CYCLES);
        end else if (cmd_db != 8'h00) begin
          state <= EXEC;
          BUSY  <= 1'b1;
          cnt   <= 32'(CMD_BUSY_CYCLES);
          if (cmd_db[7]) begin
            if (addr_valid(cmd_db[6:0])) begin
              CURSOR_ADDR <= cmd_db[6:0];
            end else begin
              CURSOR_ADDR <= 7'd0;
              CMD_ERROR   <= 1'b1;
            end
          end else if (cmd_db[6]) begin
            // CG RAM is not modelled; the access only costs busy time.
          end else if (cmd_db[5]) begin
            FUNC_8BIT  <= cmd_db[4];
            FUNC_2LINE <= cmd_db[3];
          end else if (cmd_db[4]) begin
            if (cmd_db[3]) SHIFT_OFFSET <= shift_step(SHIFT_OFFSET, !cmd_db[2]);
            else           CURSOR_ADDR  <= ac_step(CURSOR_ADDR, cmd_db[2]);
          end else if (cmd_db[3]) begin
            DISPLAY_ON <= cmd_db[2];
            CURSOR_ON  <= cmd_db[1];
            BLINK_ON   <= cmd_db[0];
          end else if (cmd_db[2]) begin
            ENTRY_INC   <= cmd_db[1];
            ENTRY_SHIFT <= cmd_db[0];
          end else if (cmd_db[1]) begin
            CURSOR_ADDR  <= 7'd0;
            SHIFT_OFFSET <= 6'd0;
            cnt          <= 32'(CLEAR_BUSY_CYCLES);
          end else begin
            CURSOR_ADDR  <= 7'd0;
            SHIFT_OFFSET <= 6'd0;
            ENTRY_INC    <= 1'b1;
            fill_idx     <= 7'd0;
            state        <= CLEARFILL;
          end
        end
      end
    end
  end

  // DD RAM write port and registered debug read port; contents survive reset.
  always_ff @(posedge CLOCK_50MHZ) begin
    if (ram_we) ram[ram_wa] <= ram_wd;
    RAM_RD_CHAR <= addr_valid(RAM_RD_ADDR) ? ram[phys(RAM_RD_ADDR)] : 8'h00;
  end

  // Drive read data while the synchronized strobe shows a read cycle.
  always_ff @(posedge CLOCK_50MHZ) begin
    if (!BUTTON_SOUTH_N) begin
      LCD_DATA_OUT <= 8'h00;
      LCD_DATA_OE  <= 1'b0;
    end else if (e_s && rw_s) begin
      LCD_DATA_OE  <= 1'b1;
      LCD_DATA_OUT <= rs_s ? ram[phys(CURSOR_ADDR)] : {BUSY, CURSOR_ADDR};
    end else begin
      LCD_DATA_OE <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lcd_char_responder.sv
// tb_lcd_char_responder: directed bench for lcd_char_responder with shortened
// busy timings. Bus reads and debug RAM reads go through an expectation queue.
module tb_lcd_char_responder;
  localparam int LL   = 40;
  localparam int PU   = 300;
  localparam int CMDB = 150;
  localparam int CLRB = 600;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] db;
  logic       e, rs, rw;
  logic [7:0] data_out;
  logic       oe, busy;
  logic [6:0] ac;
  logic [5:0] shift;
  logic       disp, cur, blink, inc, eshift, f8, f2, err;
  logic [6:0] rd_addr;
  logic [7:0] rd_char;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  lcd_char_responder #(
    .SYNC_STAGES(2), .POWERUP_CYCLES(PU), .CMD_BUSY_CYCLES(CMDB),
    .CLEAR_BUSY_CYCLES(CLRB), .LINE_LENGTH(LL)
  ) dut (
    .CLOCK_50MHZ(clk), .BUTTON_SOUTH_N(rst_n), .LCD_DATA_BIT(db),
    .LCD_ENABLE(e), .LCD_REGISTER_SELECT(rs), .LCD_READ_WRITE(rw),
    .LCD_DATA_OUT(data_out), .LCD_DATA_OE(oe), .BUSY(busy),
    .CURSOR_ADDR(ac), .SHIFT_OFFSET(shift), .DISPLAY_ON(disp),
    .CURSOR_ON(cur), .BLINK_ON(blink), .ENTRY_INC(inc), .ENTRY_SHIFT(eshift),
    .FUNC_8BIT(f8), .FUNC_2LINE(f2), .CMD_ERROR(err),
    .RAM_RD_ADDR(rd_addr), .RAM_RD_CHAR(rd_char)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic r, input logic [7:0] d);
    rs = r; rw = 1'b0; db = d; e = 1'b1;
    tick(4);
    e = 1'b0;
    tick(4);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 4000) begin
      tick(1);
      n++;
    end
    check(tag, {7'd0, busy}, 8'h00);
  endtask

  task automatic cmd(input logic [7:0] d, input string tag);
    bus_write(1'b0, d);
    wait_ready(tag);
  endtask

  task automatic bus_read(input logic r, input string tag, input logic [7:0] exp);
    int n = 0;
    exp_t x;
    x.tag = tag;
    x.val = exp;
    exp_q.push_back(x);
    rs = r; rw = 1'b1; e = 1'b1;
    while (oe !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    x = exp_q.pop_front();
    check({x.tag, "_oe"}, {7'd0, oe}, 8'h01);
    check(x.tag, data_out, x.val);
    e = 1'b0;
    tick(4);
    rw = 1'b0;
    tick(1);
  endtask

  task automatic ram_check(input logic [6:0] a, input string tag, input logic [7:0] exp);
    exp_t x;
    x.tag = tag;
    x.val = exp;
    exp_q.push_back(x);
    rd_addr = a;
    tick(1);
    x = exp_q.pop_front();
    check(x.tag, rd_char, x.val);
  endtask

  initial begin
    string      msg;
    logic [7:0] init_seq [7];
    logic [6:0] a;
    init_seq = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h07, 8'h0C, 8'h01};
    msg = "Demmy's desk!!";

    rst_n = 1'b0; e = 1'b0; rs = 1'b0; rw = 1'b0; db = 8'h00; rd_addr = 7'd0;
    tick(3);
    check("rst_data_out", data_out, 8'h00);
    check("rst_oe", {7'd0, oe}, 8'h00);
    check("rst_ac", {1'b0, ac}, 8'h00);
    check("rst_shift", {2'b0, shift}, 8'h00);
    check("rst_disp", {5'd0, disp, cur, blink}, 8'h00);
    check("rst_entry", {6'd0, inc, eshift}, 8'h02);
    check("rst_func", {6'd0, f8, f2}, 8'h02);
    check("rst_err", {7'd0, err}, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'h01);
    rst_n = 1'b1;
    tick(10);
    check("powerup_busy", {7'd0, busy}, 8'h01);
    wait_ready("powerup_done");

    // Initialisation sequence ending with clear display
    foreach (init_seq[i]) cmd(init_seq[i], $sformatf("init_%0d", i));
    check("init_func", {6'd0, f8, f2}, 8'h03);
    check("init_entry", {6'd0, inc, eshift}, 8'h03);
    check("init_disp", {5'd0, disp, cur, blink}, 8'h04);
    check("init_err", {7'd0, err}, 8'h00);
    for (int i = 0; i < 2 * LL; i++) begin
      a = (i < LL) ? 7'(i) : 7'(64 + i - LL);
      ram_check(a, $sformatf("clear_ram_%0h", a), 8'h20);
    end

    // Text write with entry shift
    cmd(8'h80, "set_ac0");
    for (int i = 0; i < msg.len(); i++) begin
      bus_write(1'b1, msg[i]);
      wait_ready("text_wr");
    end
    ram_check(7'h00, "text_first", 8'h44);
    ram_check(7'h05, "text_quote", 8'h27);
    ram_check(7'h0D, "text_last", 8'h21);
    check("text_ac", {1'b0, ac}, 8'h0E);
    check("text_shift", {2'b0, shift}, 8'd14);

    // Display shift and cursor moves
    cmd(8'h18, "shift_r");
    check("shift_15", {2'b0, shift}, 8'd15);
    repeat (25) cmd(8'h18, "shift_r");
    check("shift_wrap", {2'b0, shift}, 8'd0);
    cmd(8'h1C, "shift_l");
    check("shift_under", {2'b0, shift}, 8'd39);
    cmd(8'h14, "ac_right");
    check("ac_right", {1'b0, ac}, 8'h0F);
    cmd(8'h10, "ac_left");
    check("ac_left", {1'b0, ac}, 8'h0E);

    // Line wrap of the address counter
    cmd(8'h04, "entry_dec");
    cmd(8'hA7, "set_ac27");
    check("ac_27", {1'b0, ac}, 8'h27);
    cmd(8'h06, "entry_inc");
    bus_write(1'b1, 8'h41);
    wait_ready("wr_A");
    ram_check(7'h27, "ram_27", 8'h41);
    check("ac_wrap_40", {1'b0, ac}, 8'h40);
    cmd(8'hE7, "set_ac67");
    bus_write(1'b1, 8'h5A);
    wait_ready("wr_Z");
    ram_check(7'h67, "ram_67", 8'h5A);
    check("ac_wrap_00", {1'b0, ac}, 8'h00);
    bus_read(1'b1, "data_read0", 8'h44);
    wait_ready("data_read_busy");
    bus_read(1'b0, "status_ac1", 8'h01);
    cmd(8'h04, "entry_dec2");
    cmd(8'hC0, "set_ac40");
    bus_write(1'b1, 8'h42);
    wait_ready("wr_B");
    check("ac_dec_27", {1'b0, ac}, 8'h27);
    cmd(8'h80, "set_ac00");
    bus_write(1'b1, 8'h43);
    wait_ready("wr_C");
    check("ac_dec_67", {1'b0, ac}, 8'h67);
    ram_check(7'h40, "ram_40", 8'h42);
    ram_check(7'h00, "ram_00", 8'h43);
    cmd(8'h06, "entry_inc2");

    // Busy flag while clearing
    bus_write(1'b0, 8'h01);
    tick(6);
    bus_read(1'b0, "status_clear", 8'h80);
    wait_ready("clear_done");
    bus_read(1'b0, "status_idle", 8'h00);
    check("clear_entry_inc", {7'd0, inc}, 8'h01);

    // Data write while a command is still busy
    bus_write(1'b0, 8'h0C);
    tick(90);
    check("busy_before_data", {7'd0, busy}, 8'h01);
    bus_write(1'b1, 8'h51);
    wait_ready("busy_wr");
`ifdef LCD_BUSY_CHECK_EN
    ram_check(7'h00, "busy_drop_ram", 8'h20);
    check("busy_drop_err", {7'd0, err}, 8'h01);
    check("busy_drop_ac", {1'b0, ac}, 8'h00);
`else
    ram_check(7'h00, "busy_exec_ram", 8'h51);
    check("busy_exec_err", {7'd0, err}, 8'h00);
    check("busy_exec_ac", {1'b0, ac}, 8'h01);
`endif

    // Invalid DD RAM address
    cmd(8'h85, "set_ac05");
    check("ac_05", {1'b0, ac}, 8'h05);
    cmd(8'hA8, "bad_addr");
    check("bad_addr_ac", {1'b0, ac}, 8'h00);
    check("bad_addr_err", {7'd0, err}, 8'h01);

    // Reset during the clear fill
    cmd(8'hE7, "set_ac67b");
    bus_write(1'b1, 8'h5A);
    wait_ready("wr_Z2");
    bus_write(1'b0, 8'h01);
    tick(4);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    check("midfill_busy", {7'd0, busy}, 8'h01);
    check("midfill_err", {7'd0, err}, 8'h00);
    check("midfill_ac", {1'b0, ac}, 8'h00);
    tick(1);
    ram_check(7'h00, "midfill_ram00", 8'h20);
    ram_check(7'h67, "midfill_ram67", 8'h5A);

    // Writes during power-up
    bus_write(1'b0, 8'h38);
    check("pu_fset", {6'd0, f8, f2}, 8'h03);
    check("pu_fset_err", {7'd0, err}, 8'h00);
    bus_write(1'b0, 8'h0C);
    check("pu_drop_err", {7'd0, err}, 8'h01);
    check("pu_drop_disp", {7'd0, disp}, 8'h00);
    check("pu_still_busy", {7'd0, busy}, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
